// File: rtl/btn_debouncer.sv
// Multi-channel button/endstop debouncer: per-channel synchroniser, shared
// sample prescaler and per-channel stability counter. The module emits
// registered debounced levels and one-cycle rise/fall pulses.
module btn_debouncer #(
  parameter int unsigned CHANNELS    = 7,
  parameter int unsigned DIV_SIZE    = 16,
  parameter int unsigned STABLE_SIZE = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [DIV_SIZE-1:0]    div_max_in,
  input  logic [STABLE_SIZE-1:0] stable_max_in,
  input  logic [CHANNELS-1:0]    btn_in,
  output logic [CHANNELS-1:0]    state_out,
  output logic [CHANNELS-1:0]    rise_out,
  output logic [CHANNELS-1:0]    fall_out,
  output logic                   tick_out
);

  // sync_q[0] samples btn_in; sync_q[SYNC_STAGES-1] is the only stage the
  // debounce logic reads. Requires SYNC_STAGES >= 2.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0]    sync_q, sync_d;
  logic [CHANNELS-1:0]                     sync_last;
  logic [DIV_SIZE-1:0]                     cnt_q, cnt_d;
  logic                                    tick_q, tick_d;
  logic [CHANNELS-1:0][STABLE_SIZE-1:0]    scnt_q, scnt_d;
  logic [CHANNELS-1:0]                     state_q, state_d;
  logic [CHANNELS-1:0]                     rise_q, rise_d;
  logic [CHANNELS-1:0]                     fall_q, fall_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchroniser shift: new raw sample enters stage 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // Prescaler: >= lets a lowered terminal count wrap on the next cycle.
  always_comb begin
    tick_d = (cnt_q >= div_max_in);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  // Stability counters; evaluated in the cycle tick_out is high, so the
  // updated level and its edge pulse appear together on the following cycle.
  always_comb begin
    scnt_d  = scnt_q;
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick_q) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sync_last[i] == state_q[i]) begin
          scnt_d[i] = '0;
        end else if (scnt_q[i] >= stable_max_in) begin
          state_d[i] = sync_last[i];
          scnt_d[i]  = '0;
          rise_d[i]  = sync_last[i];
          fall_d[i]  = ~sync_last[i];
        end else begin
          scnt_d[i] = scnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      scnt_q  <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      scnt_q  <= scnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state_out = state_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;
  assign tick_out  = tick_q;

endmodule
